imem_fetch_ctrl: RTL and testbench
==================================

IMEM_FETCH_CTRL -- requirements
Module: imem_fetch_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 8'h00: PC value loaded at reset.
REQ-002 SHALL have parameter HALT_OPC, default 4'hF: opcode field, instr[15:12], that halts fetch.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  level/pulse; leaves IDLE.
REQ-006 SHALL have port imem_addr  output  8  word address to instruction memory (combinational-read memory).
REQ-007 SHALL have port imem_instr  input  16  instruction word returned for imem_addr in the same cycle.
REQ-008 SHALL have port redirect_valid  input  1  branch/jump request.
REQ-009 SHALL have port redirect_addr  input  8  target PC.
REQ-010 SHALL have port out_valid  output  1  fetched instruction available.
REQ-011 SHALL have port out_ready  input  1  decode accepts when out_valid && out_ready.
REQ-012 SHALL have port out_instr  output  16  registered instruction.
REQ-013 SHALL have port out_pc  output  8  address of out_instr.
REQ-014 SHALL have port halted  output  1  high in HALTED state.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, HALTED.
REQ-016 IDLE -> RUN when start=1; RUN -> HALTED on capture of an instruction with opcode HALT_OPC; HALTED -> RUN on redirect_valid; no other transitions.
REQ-017 imem_addr SHALL equal the PC register at all times.
REQ-018 Output slot free := !out_valid || out_ready.
REQ-019 In RUN with slot free and no redirect: capture out_instr<=imem_instr, out_pc<=pc, out_valid<=1, pc<=pc+1.
REQ-020 PC increment SHALL be modulo 256 (8'hFF -> 8'h00), no flag.
REQ-021 Slot not free: out_instr, out_pc, out_valid, pc held unchanged (stall).
REQ-022 In IDLE/HALTED with slot free: out_valid<=0; no capture, pc held.
REQ-023 Latency: start seen at edge k -> out_valid=1, out_pc=RESET_PC after edge k+1; throughput 1 instr/cycle with out_ready=1.
REQ-024 redirect_valid (any state except IDLE) SHALL have top priority: pc<=redirect_addr, out_valid<=0 at same edge regardless of out_ready, no capture that cycle; first target instruction valid one edge later.
REQ-025 redirect_valid in IDLE SHALL load pc<=redirect_addr and remain IDLE.
REQ-026 HALT_OPC instruction SHALL itself be delivered on out_* before fetch stops; pc advances past it.
REQ-027 start while in RUN or HALTED SHALL be ignored.

Reset
REQ-028 rst_n low SHALL asynchronously force state=IDLE, pc=RESET_PC, out_valid=0, out_instr=16'h0000, out_pc=8'h00, halted=0, counters=0.
REQ-029 Reset asserted mid-stall or mid-redirect SHALL discard all in-flight state; release resumes in IDLE.

Configuration
REQ-030 Macro FETCH_PERF_CNT_EN defined: add outputs fetch_cnt[15:0] (captures, per REQ-019) and stall_cnt[15:0] (cycles in RUN with out_valid && !out_ready), both saturating at 16'hFFFF.
REQ-031 Macro undefined: ports and counters absent; all other behaviour identical.

Structure
REQ-032 Shared package SHALL hold state encoding (IDLE=2'd0, RUN=2'd1, HALTED=2'd2), instruction opcode field positions [15:12], and default HALT_OPC.
REQ-033 Counter logic SHALL be one sub-module, fetch_perf_cnt, instantiated only under FETCH_PERF_CNT_EN; otherwise flat.

Verification
REQ-034 Memory 0:16'h4100,1:16'h4202,2:16'h0321, out_ready=1, start pulse -> out_pc 0,1,2 on consecutive cycles with those words.
REQ-035 out_ready=0 for 3 cycles while out_pc=1 -> out_instr stays 16'h4202, imem_addr stays 8'h02; stall_cnt=3 when macro defined.
REQ-036 redirect_valid with redirect_addr=8'h10 while out_valid && !out_ready -> out_valid 0 next cycle, then out_pc=8'h10.
REQ-037 mem[3]=16'hF000 -> out_pc=3 delivered, halted=1, imem_addr=8'h04 held; redirect to 8'h00 -> RUN, out_pc=0.
REQ-038 redirect to 8'hFF, out_ready=1 -> out_pc 8'hFF then 8'h00.
REQ-039 rst_n low mid-stream (asynchronous, between edges) -> out_valid=0, imem_addr=RESET_PC immediately; IDLE until start.

Source files
------------

// File: rtl/imem_fetch_ctrl_pkg.sv
// Shared definitions for the instruction fetch controller:
// FSM state encoding, opcode field position, default halt opcode.
package imem_fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } fetch_state_t;

  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;

  localparam logic [3:0] HALT_OPC_DEF = 4'hF;

  function automatic logic [3:0] opc_of(
    input logic [15:0] instr
  );
    return instr[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/imem_fetch_ctrl_perf_cnt.sv
// Saturating fetch/stall event counters for the fetch controller.
// Ports: clk, rst_n, fetch_inc, stall_inc -> fetch_cnt, stall_cnt.
// Compiled only when FETCH_PERF_CNT_EN is defined.
`ifdef FETCH_PERF_CNT_EN
module fetch_perf_cnt
  import imem_fetch_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_inc,
  input  logic        stall_inc,
  output logic [15:0] fetch_cnt,
  output logic [15:0] stall_cnt
);

  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt <= 16'h0000;
      stall_cnt <= 16'h0000;
    end else begin
      if (fetch_inc && (fetch_cnt != CNT_MAX))
        fetch_cnt <= fetch_cnt + 16'h0001;
      if (stall_inc && (stall_cnt != CNT_MAX))
        stall_cnt <= stall_cnt + 16'h0001;
    end
  end

endmodule
`endif

// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch controller: IDLE/RUN/HALTED FSM driving a
// combinational-read instruction memory into a one-entry output slot.
// Ports: clk, rst_n, start, imem_addr/imem_instr, redirect_valid/addr,
//        out_valid/out_ready/out_instr/out_pc, halted.
// Optional FETCH_PERF_CNT_EN adds fetch_cnt and stall_cnt outputs.
module imem_fetch_ctrl
  import imem_fetch_ctrl_pkg::*;
#(
  parameter logic [7:0] RESET_PC = 8'h00,
  parameter logic [3:0] HALT_OPC = HALT_OPC_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [7:0]  imem_addr,
  input  logic [15:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [7:0]  redirect_addr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_instr,
  output logic [7:0]  out_pc,
  output logic        halted
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0] fetch_cnt,
  output logic [15:0] stall_cnt
`endif
);

  fetch_state_t state;
  logic [7:0]   pc;
  logic         slot_free;
  logic         capture;
  logic         is_halt;

  assign imem_addr = pc;
  assign slot_free = !out_valid || out_ready;
  assign is_halt   = (opc_of(imem_instr) == HALT_OPC);

  // A redirect always wins, so no capture happens in that cycle.
  assign capture = (state == ST_RUN) && slot_free
                   && !redirect_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      pc        <= RESET_PC;
      out_valid <= 1'b0;
      out_instr <= 16'h0000;
      out_pc    <= 8'h00;
      halted    <= 1'b0;
    end else if (redirect_valid) begin
      pc <= redirect_addr;
      // In IDLE only the PC is preloaded; fetch still waits for start.
      if (state != ST_IDLE) begin
        state     <= ST_RUN;
        halted    <= 1'b0;
        out_valid <= 1'b0;
      end
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (slot_free)
            out_valid <= 1'b0;
          if (start)
            state <= ST_RUN;
        end
        ST_RUN: begin
          if (slot_free) begin
            out_instr <= imem_instr;
            out_pc    <= pc;
            out_valid <= 1'b1;
            pc        <= pc + 8'd1;
            // The halt word itself is delivered; fetch stops after it.
            if (is_halt) begin
              state  <= ST_HALTED;
              halted <= 1'b1;
            end
          end
        end
        ST_HALTED: begin
          if (slot_free)
            out_valid <= 1'b0;
        end
        default: begin
          state  <= ST_IDLE;
          halted <= 1'b0;
        end
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic stall;

  assign stall = (state == ST_RUN) && out_valid
                 && !out_ready;

  fetch_perf_cnt u_perf (
    .clk       (clk),
    .rst_n     (rst_n),
    .fetch_inc (capture),
    .stall_inc (stall),
    .fetch_cnt (fetch_cnt),
    .stall_cnt (stall_cnt)
  );
`else
  logic unused_capture;
  assign unused_capture = capture;
`endif

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed self-checking bench for imem_fetch_ctrl.
// Counter checks are included when FETCH_PERF_CNT_EN is defined.
module tb_imem_fetch_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  imem_addr;
  logic [15:0] imem_instr;
  logic        redirect_valid;
  logic [7:0]  redirect_addr;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_instr;
  logic [7:0]  out_pc;
  logic        halted;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] fetch_cnt;
  logic [15:0] stall_cnt;
`endif

  logic [15:0] mem [256];

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  assign imem_instr = mem[imem_addr];

  imem_fetch_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .halted         (halted)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_cnt      (fetch_cnt),
    .stall_cnt      (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [15:0] obs,
    input logic [15:0] exp
  );
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(
    input string       tag,
    input logic        v,
    input logic [7:0]  pc,
    input logic [15:0] ins,
    input logic [7:0]  addr
  );
    chk({tag, ".valid"}, {15'd0, out_valid}, {15'd0, v});
    chk({tag, ".pc"}, {8'd0, out_pc}, {8'd0, pc});
    chk({tag, ".instr"}, out_instr, ins);
    chk({tag, ".addr"}, {8'd0, imem_addr}, {8'd0, addr});
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[0]   = 16'h4100;
    mem[1]   = 16'h4202;
    mem[2]   = 16'h0321;
    mem[3]   = 16'hF000;
    mem[16]  = 16'h1234;
    mem[255] = 16'hABCD;

    rst_n = 1'b0;
    start = 1'b0;
    out_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_addr = 8'h00;

    #1;
    chk_out("reset", 1'b0, 8'h00, 16'h0000, 8'h00);
    chk("reset.halted", {15'd0, halted}, 16'd0);
`ifdef FETCH_PERF_CNT_EN
    chk("reset.fcnt", fetch_cnt, 16'd0);
    chk("reset.scnt", stall_cnt, 16'd0);
`endif
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk_out("idle", 1'b0, 8'h00, 16'h0000, 8'h00);

    // start at edge k, first word after edge k+1
    start = 1'b1;
    tick();
    start = 1'b0;
    chk_out("start_k", 1'b0, 8'h00, 16'h0000, 8'h00);
    tick();
    chk_out("f0", 1'b1, 8'h00, 16'h4100, 8'h01);
    tick();
    chk_out("f1", 1'b1, 8'h01, 16'h4202, 8'h02);

    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out("stall", 1'b1, 8'h01, 16'h4202, 8'h02);
    end
`ifdef FETCH_PERF_CNT_EN
    chk("stall.scnt", stall_cnt, 16'd3);
`endif
    out_ready = 1'b1;
    tick();
    chk_out("f2", 1'b1, 8'h02, 16'h0321, 8'h03);
    tick();
    chk_out("f3halt", 1'b1, 8'h03, 16'hF000, 8'h04);
    chk("f3.halted", {15'd0, halted}, 16'd1);
    tick();
    chk_out("halt1", 1'b0, 8'h03, 16'hF000, 8'h04);
    chk("halt1.halted", {15'd0, halted}, 16'd1);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk_out("halt2", 1'b0, 8'h03, 16'hF000, 8'h04);
    chk("halt2.halted", {15'd0, halted}, 16'd1);

    // leave HALTED via redirect to 0
    redirect_valid = 1'b1;
    redirect_addr = 8'h00;
    tick();
    redirect_valid = 1'b0;
    chk_out("rd0", 1'b0, 8'h03, 16'hF000, 8'h00);
    chk("rd0.halted", {15'd0, halted}, 16'd0);
    tick();
    chk_out("rd0.f0", 1'b1, 8'h00, 16'h4100, 8'h01);
    tick();
    chk_out("rd0.f1", 1'b1, 8'h01, 16'h4202, 8'h02);

    // redirect while stalled
    out_ready = 1'b0;
    tick();
    chk_out("st2", 1'b1, 8'h01, 16'h4202, 8'h02);
    redirect_valid = 1'b1;
    redirect_addr = 8'h10;
    tick();
    redirect_valid = 1'b0;
    chk_out("rd10", 1'b0, 8'h01, 16'h4202, 8'h10);
    tick();
    chk_out("rd10.f", 1'b1, 8'h10, 16'h1234, 8'h11);
`ifdef FETCH_PERF_CNT_EN
    chk("rd10.fcnt", fetch_cnt, 16'd7);
    chk("rd10.scnt", stall_cnt, 16'd5);
`endif
    out_ready = 1'b1;

    // PC wrap
    redirect_valid = 1'b1;
    redirect_addr = 8'hFF;
    tick();
    redirect_valid = 1'b0;
    chk_out("rdff", 1'b0, 8'h10, 16'h1234, 8'hFF);
    tick();
    chk_out("wrap.ff", 1'b1, 8'hFF, 16'hABCD, 8'h00);
    tick();
    chk_out("wrap.00", 1'b1, 8'h00, 16'h4100, 8'h01);

    // asynchronous reset between edges
    #3;
    rst_n = 1'b0;
    #1;
    chk_out("areset", 1'b0, 8'h00, 16'h0000, 8'h00);
    chk("areset.halted", {15'd0, halted}, 16'd0);
`ifdef FETCH_PERF_CNT_EN
    chk("areset.fcnt", fetch_cnt, 16'd0);
`endif
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    chk_out("post_rst", 1'b0, 8'h00, 16'h0000, 8'h00);

    // redirect in IDLE preloads PC but stays idle
    redirect_valid = 1'b1;
    redirect_addr = 8'h02;
    tick();
    redirect_valid = 1'b0;
    chk_out("idle_rd", 1'b0, 8'h00, 16'h0000, 8'h02);
    tick();
    chk_out("idle_rd2", 1'b0, 8'h00, 16'h0000, 8'h02);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk_out("idle_rd.f", 1'b1, 8'h02, 16'h0321, 8'h03);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
